cdc_handshake_rx: RTL and testbench
===================================

Name: cdc_handshake_rx

Overview:
- Destination end of a 4-phase req/ack CDC bus-transfer protocol.
- Source domain drives src_req plus stable src_data. This block:
  - synchronizes src_req into dest_clk,
  - captures the word,
  - presents it on a valid/ready interface,
  - returns dest_ack (registered in dest_clk) for the source side to synchronize back.
- One word in flight at a time; no FIFO.

Parameters:
- WIDTH, 32, data word width in bits; legal range 1 or more.
- STAGES, 2, number of req synchronizer flops; legal range 2 or more.

Ports:
- dest_clk  input  1  destination clock.
- rst_n  input  1  reset, synchronous to dest_clk, active-low.
- src_req  input  1  asynchronous request from source domain; level signal.
- src_data  input  WIDTH  asynchronous data; source guarantees it is stable from src_req rise until it sees dest_ack high.
- dest_ack  output  1  acknowledge to source domain; driven directly from a flop, no combinational path.
- m_valid  output  1  captured word available.
- m_ready  input  1  downstream consumer accepts the word.
- m_data  output  WIDTH  captured word; registered.

Behaviour:
- Reset: synchronous, active-low, on dest_clk. While rst_n=0 at a clock edge:
  - sync flops <= 0, state <= IDLE;
  - m_valid=0, dest_ack=0, m_data=0.
- Reset takes priority over all other events.
- req_s: last stage of a STAGES-deep flop chain sampling src_req. Chain flops carry the ASYNC_REG attribute. Only the synchronized value is used. src_data is never synchronized; it is sampled only as described below.
- IDLE (m_valid=0, dest_ack=0): if req_s=1, then m_data <= src_data, m_valid <= 1, go to VALID.
- VALID (m_valid=1, dest_ack=0):
  - m_data holds constant.
  - If m_ready=1, then m_valid <= 0, dest_ack <= 1, go to ACK_HI.
  - If m_ready=0, stay; no timeout.
- ACK_HI (m_valid=0, dest_ack=1): if req_s=0, then dest_ack <= 0, go to IDLE. req_s stuck high holds ACK_HI indefinitely.
- Latency:
  - src_req rise sampled at edge k → req_s=1 after edge k+STAGES-1 → m_valid=1 after edge k+STAGES.
  - Accept edge (m_valid & m_ready) → dest_ack=1 at the same edge.
  - req_s fall → dest_ack=0 one edge later.
- m_valid is never combinationally dependent on m_ready.
- m_ready=1 while m_valid=0 is ignored.
- A new capture requires passage through ACK_HI → IDLE, so one src_req pulse yields exactly one m_valid transfer. No duplicate or lost words while the protocol is obeyed.
- Simultaneous req_s=0 and m_ready=1 in VALID (protocol violation by source):
  - the word is still delivered, then ACK_HI;
  - ACK_HI exits on the next edge since req_s=0.
- Reset mid-transfer:
  - Word in VALID is discarded and dest_ack drops.
  - If req_s is still 1 after reset release, the request is treated as new and captured again. The source side is reset in the same system reset and must not hold req across reset.
- Minimum round-trip from accept to returning to IDLE is bounded by source-side synchronization; the block adds no extra delay states.

Optional Feature:
- Macro: CDC_HANDSHAKE_RX_CHECK_EN.
- Defined: adds simulation-only protocol checks, excluded from synthesis, each reporting $error with time and state:
  - (a) src_data changes while req_s=1 and dest_ack=0;
  - (b) req_s falls while in VALID;
  - (c) req_s rises again before dest_ack has returned to 0 (ACK_HI must see 0 first);
  - (d) m_data changes while m_valid=1.
- Checks are disabled while rst_n=0 and for STAGES cycles after release.
- Undefined: no checks. Functional RTL is identical with and without the macro.

Test Plan:
- Reset: rst_n=0 for 3 cycles with src_req=1, src_data=32'hFFFF_FFFF → m_valid=0, dest_ack=0, m_data=0 throughout reset.
- Single transfer, STAGES=2, m_ready=1:
  - src_req rises with src_data=32'hDEAD_BEEF → m_valid=1 with m_data=32'hDEAD_BEEF two edges after first req sample;
  - accepted same cycle; dest_ack=1 next;
  - src_req drops → dest_ack=0 one edge after req_s=0.
- Backpressure: m_ready=0 for 10 cycles after capture of 32'h1234_5678 → m_valid stays 1, m_data stable, dest_ack=0; m_ready=1 → single accept, dest_ack rises.
- Burst: 8 back-to-back 4-phase transfers of values 0..7 from a model source in an async clock (ratio 1:2.7, random phase) → consumer receives exactly 0..7 in order, no duplicates.
- Reset mid-operation: reset asserted while in VALID holding 32'hA5A5_A5A5 → m_valid=0, dest_ack=0 next edge; source model also reset; the next transfer of 32'h0000_0001 is delivered correctly.
- STAGES=3, WIDTH=8: src_data=8'h3C → m_valid rises three edges after first req sample; with CDC_HANDSHAKE_RX_CHECK_EN defined, deliberately changing src_data mid-request triggers exactly one $error.

Source files
------------

// File: rtl/cdc_handshake_rx.sv
// rtl/cdc_handshake_rx.sv - destination end of a 4-phase req/ack CDC word transfer
//
// Synchronizes src_req into dest_clk, captures src_data once the request is
// seen, offers the word on a valid/ready interface and returns dest_ack from
// a flop for the source side to synchronize back. One word in flight.
//
// Parameters:
//   WIDTH   data word width (>= 1)
//   STAGES  depth of the src_req synchronizer (>= 2)
//
// Ports:
//   dest_clk  in   destination clock
//   rst_n     in   synchronous active-low reset
//   src_req   in   asynchronous request level from the source domain
//   src_data  in   source word, held stable by the source until it sees dest_ack
//   dest_ack  out  acknowledge level back to the source domain (flop output)
//   m_valid   out  captured word available
//   m_ready   in   consumer accepts the word
//   m_data    out  captured word (registered)
//
// Optional build macro: CDC_HANDSHAKE_RX_CHECK_EN adds simulation-only
// protocol checks; the functional logic is the same either way.

module cdc_handshake_rx #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             dest_clk,
    input  logic             rst_n,
    input  logic             src_req,
    input  logic [WIDTH-1:0] src_data,
    output logic             dest_ack,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VALID  = 2'd1,
        ACK_HI = 2'd2
    } state_t;

    state_t state;
    state_t state_d;

    // Request synchronizer. Only the last stage is ever used.
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] req_sync;
    logic req_s;

    always_ff @(posedge dest_clk) begin
        if (!rst_n) begin
            req_sync <= '0;
        end else begin
            req_sync <= {req_sync[STAGES-2:0], src_req};
        end
    end

    assign req_s = req_sync[STAGES-1];

    // State register
    always_ff @(posedge dest_clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic. A fresh capture is only possible after ACK_HI has
    // seen req_s low, which is what keeps one request to one transfer.
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (req_s) begin
                    state_d = VALID;
                end
            end
            VALID: begin
                if (m_ready) begin
                    state_d = ACK_HI;
                end
            end
            ACK_HI: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode. The decoded values are registered below so that
    // m_valid and dest_ack come straight off flops and change on the same
    // edge as the state transition that implies them.
    logic valid_d;
    logic ack_d;
    logic capture;

    always_comb begin
        valid_d = 1'b0;
        ack_d   = 1'b0;
        capture = 1'b0;
        case (state_d)
            VALID:   valid_d = 1'b1;
            ACK_HI:  ack_d   = 1'b1;
            default: begin
                valid_d = 1'b0;
                ack_d   = 1'b0;
            end
        endcase
        if (state == IDLE && req_s) begin
            capture = 1'b1;
        end
    end

    always_ff @(posedge dest_clk) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            dest_ack <= 1'b0;
            m_data   <= '0;
        end else begin
            m_valid  <= valid_d;
            dest_ack <= ack_d;
            if (capture) begin
                m_data <= src_data;
            end
        end
    end

`ifdef CDC_HANDSHAKE_RX_CHECK_EN
`ifndef SYNTHESIS
    // Protocol monitors. They stay quiet during reset and for STAGES cycles
    // afterwards while the synchronizer flushes.
    int               chk_hold;
    logic             prev_req_s;
    logic             prev_window;
    logic             prev_valid;
    logic [WIDTH-1:0] prev_src_data;
    logic [WIDTH-1:0] prev_m_data;

    always_ff @(posedge dest_clk) begin
        if (!rst_n) begin
            chk_hold      <= 0;
            prev_req_s    <= 1'b0;
            prev_window   <= 1'b0;
            prev_valid    <= 1'b0;
            prev_src_data <= '0;
            prev_m_data   <= '0;
        end else begin
            if (chk_hold < STAGES) begin
                chk_hold <= chk_hold + 1;
            end
            prev_req_s    <= req_s;
            prev_window   <= req_s && !dest_ack;
            prev_valid    <= m_valid;
            prev_src_data <= src_data;
            prev_m_data   <= m_data;

            if (chk_hold >= STAGES) begin
                if (prev_window && req_s && !dest_ack && src_data != prev_src_data) begin
                    $error("cdc_handshake_rx: src_data changed during request at %0t state=%s",
                           $time, state.name());
                end
                if (state == VALID && prev_req_s && !req_s) begin
                    $error("cdc_handshake_rx: req_s fell while word pending at %0t state=%s",
                           $time, state.name());
                end
                if (!prev_req_s && req_s && dest_ack) begin
                    $error("cdc_handshake_rx: req_s rose before ack returned low at %0t state=%s",
                           $time, state.name());
                end
                if (prev_valid && m_valid && m_data != prev_m_data) begin
                    $error("cdc_handshake_rx: m_data changed while valid at %0t state=%s",
                           $time, state.name());
                end
            end
        end
    end
`endif
`endif

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// tb/tb_cdc_handshake_rx.sv - self-checking bench for cdc_handshake_rx
`timescale 1ns/1ps

module tb_cdc_handshake_rx;

    logic        dest_clk = 1'b0;
    logic        src_clk  = 1'b0;
    logic        rst_n;

    logic        src_req;
    logic [31:0] src_data;
    logic        dest_ack;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;

    logic        req3;
    logic [7:0]  data3;
    logic        ack3;
    logic        valid3;
    logic        ready3;
    logic [7:0]  mdata3;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sent_q[$];
    logic [31:0] got_q[$];

    logic ack_m = 1'b0;
    logic ack_s = 1'b0;

    cdc_handshake_rx #(.WIDTH(32), .STAGES(2)) dut (
        .dest_clk (dest_clk),
        .rst_n    (rst_n),
        .src_req  (src_req),
        .src_data (src_data),
        .dest_ack (dest_ack),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data)
    );

    cdc_handshake_rx #(.WIDTH(8), .STAGES(3)) dut3 (
        .dest_clk (dest_clk),
        .rst_n    (rst_n),
        .src_req  (req3),
        .src_data (data3),
        .dest_ack (ack3),
        .m_valid  (valid3),
        .m_ready  (ready3),
        .m_data   (mdata3)
    );

    always #5 dest_clk = ~dest_clk;

    // Source clock at 2.7x the destination period with a random start phase.
    initial begin
        #(real'($urandom_range(0, 2699)) / 100.0 + 0.37);
        forever #13.5 src_clk = ~src_clk;
    end

    // Source-side synchronizer for dest_ack.
    always @(posedge src_clk) begin
        ack_m <= dest_ack;
        ack_s <= ack_m;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge dest_clk);
        #1;
    endtask

    // One 4-phase transfer from the source-domain model.
    task automatic src_send(input logic [31:0] w);
        int cnt;
        @(posedge src_clk);
        src_data = w;
        src_req  = 1'b1;
        sent_q.push_back(w);
        cnt = 0;
        while (!ack_s && cnt < 400) begin
            @(posedge src_clk);
            cnt++;
        end
        if (!ack_s) check_val("src_ack_rise_timeout", 32'(ack_s), 32'd1);
        @(posedge src_clk);
        src_req = 1'b0;
        cnt = 0;
        while (ack_s && cnt < 400) begin
            @(posedge src_clk);
            cnt++;
        end
        if (ack_s) check_val("src_ack_fall_timeout", 32'(ack_s), 32'd0);
    endtask

    // Source sends n words while a consumer with random backpressure drains
    // them; received words must equal sent words, in order.
    task automatic run_burst(input int n, input bit rnd, input logic [31:0] base);
        sent_q.delete();
        got_q.delete();
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    src_send(rnd ? 32'($urandom) : base + 32'(i));
                end
            end
            begin
                logic        lv, lr;
                logic [31:0] ld;
                int          cyc;
                lv = 1'b0; lr = 1'b0; ld = '0;
                cyc = 0;
                while (got_q.size() < n && cyc < 6000) begin
                    step();
                    cyc++;
                    if (lv && lr) got_q.push_back(ld);
                    m_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                    lv = m_valid;
                    lr = m_ready;
                    ld = m_data;
                end
                m_ready = 1'b0;
            end
        join
        check_val("burst_count", 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check_val($sformatf("burst_word%0d", i), got_q[i], sent_q[i]);
        end
    endtask

    initial begin
        int cnt;
        logic [31:0] held;

        rst_n    = 1'b0;
        src_req  = 1'b1;
        src_data = 32'hFFFF_FFFF;
        m_ready  = 1'b0;
        req3     = 1'b1;
        data3    = 8'hFF;
        ready3   = 1'b0;

        // Reset with a request pending
        for (int i = 0; i < 3; i++) begin
            step();
            check_val("rst_valid", 32'(m_valid), 32'd0);
            check_val("rst_ack", 32'(dest_ack), 32'd0);
            check_val("rst_data", m_data, 32'd0);
        end
        src_req = 1'b0;
        req3    = 1'b0;
        rst_n   = 1'b1;
        repeat (4) step();

        // Single transfer, ready held high
        src_data = 32'hDEAD_BEEF;
        src_req  = 1'b1;
        m_ready  = 1'b1;
        step();
        check_val("single_valid_k", 32'(m_valid), 32'd0);
        step();
        check_val("single_valid_k1", 32'(m_valid), 32'd0);
        step();
        check_val("single_valid_k2", 32'(m_valid), 32'd1);
        check_val("single_data", m_data, 32'hDEAD_BEEF);
        check_val("single_ack_k2", 32'(dest_ack), 32'd0);
        step();
        check_val("single_valid_k3", 32'(m_valid), 32'd0);
        check_val("single_ack_k3", 32'(dest_ack), 32'd1);
        src_req = 1'b0;
        step();
        check_val("single_ack_hold1", 32'(dest_ack), 32'd1);
        step();
        check_val("single_ack_hold2", 32'(dest_ack), 32'd1);
        step();
        check_val("single_ack_drop", 32'(dest_ack), 32'd0);
        m_ready = 1'b0;
        repeat (2) step();

        // Backpressure
        src_data = 32'h1234_5678;
        src_req  = 1'b1;
        cnt = 0;
        while (!m_valid && cnt < 10) begin
            step();
            cnt++;
        end
        check_val("bp_valid_rise", 32'(m_valid), 32'd1);
        check_val("bp_data", m_data, 32'h1234_5678);
        for (int i = 0; i < 10; i++) begin
            step();
            check_val("bp_hold_valid", 32'(m_valid), 32'd1);
            check_val("bp_hold_data", m_data, 32'h1234_5678);
            check_val("bp_hold_ack", 32'(dest_ack), 32'd0);
        end
        m_ready = 1'b1;
        step();
        check_val("bp_accept_valid", 32'(m_valid), 32'd0);
        check_val("bp_accept_ack", 32'(dest_ack), 32'd1);
        step();
        check_val("bp_no_dup", 32'(m_valid), 32'd0);
        m_ready = 1'b0;
        src_req = 1'b0;
        cnt = 0;
        while (dest_ack && cnt < 10) begin
            step();
            cnt++;
        end
        check_val("bp_ack_fall", 32'(dest_ack), 32'd0);
        repeat (2) step();

        // Three-stage, 8-bit instance
        data3 = 8'h3C;
        req3  = 1'b1;
        step();
        check_val("s3_valid_k", 32'(valid3), 32'd0);
        step();
        check_val("s3_valid_k1", 32'(valid3), 32'd0);
        step();
        check_val("s3_valid_k2", 32'(valid3), 32'd0);
        step();
        check_val("s3_valid_k3", 32'(valid3), 32'd1);
        check_val("s3_data", 32'(mdata3), 32'h3C);
        ready3 = 1'b1;
        step();
        check_val("s3_ack", 32'(ack3), 32'd1);
        ready3 = 1'b0;
        req3   = 1'b0;
        cnt = 0;
        while (ack3 && cnt < 10) begin
            step();
            cnt++;
        end
        check_val("s3_ack_fall", 32'(ack3), 32'd0);
`ifdef CDC_HANDSHAKE_RX_CHECK_EN
        data3 = 8'h11;
        req3  = 1'b1;
        repeat (5) step();
        data3 = 8'h22;
        repeat (2) step();
        ready3 = 1'b1;
        step();
        ready3 = 1'b0;
        req3   = 1'b0;
        repeat (6) step();
`endif

        // Async-clock bursts
        run_burst(8, 1'b0, 32'd0);
        run_burst(12, 1'b1, 32'd0);
        repeat (3) step();

        // Reset while a word is pending
        src_data = 32'hA5A5_A5A5;
        src_req  = 1'b1;
        m_ready  = 1'b0;
        cnt = 0;
        while (!m_valid && cnt < 10) begin
            step();
            cnt++;
        end
        held = m_data;
        check_val("midrst_pending", held, 32'hA5A5_A5A5);
        rst_n   = 1'b0;
        src_req = 1'b0;
        step();
        check_val("midrst_valid", 32'(m_valid), 32'd0);
        check_val("midrst_ack", 32'(dest_ack), 32'd0);
        rst_n = 1'b1;
        repeat (3) step();
        run_burst(1, 1'b0, 32'h0000_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
